// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : step_ctrl
// Purpose  : Push-button driven processor step controller offering halt,
//            single-step, fixed-length burst and free-running step modes.
// Revision : 1.0 - initial release
// ============================================================================
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int DIV_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             CLK_BUTT,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [DIV_W-1:0] run_div,
    output logic             step_en,
    output logic             busy,
    output logic             burst_done,
    output logic [CNT_W-1:0] step_count
);

    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_MODE_STEP  = 2'b01;
    localparam logic [1:0] c_MODE_BURST = 2'b10;
    localparam logic [1:0] c_MODE_RUN   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_BURST = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic              r_db_prev;
    logic [c_DB_W-1:0] r_db_cnt;
    state_t            r_state;
    logic              r_step_en;
    logic              r_busy;
    logic              r_burst_done;
    logic [CNT_W-1:0]  r_remaining;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_step_count;

    logic              w_press;
    state_t            w_state_nxt;
    logic              w_step_en_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [CNT_W-1:0]  w_remaining_nxt;
    logic [DIV_W-1:0]  w_div_nxt;

    // Level is accepted only after a full run of disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= CLK_BUTT;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_MAX) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end
    end

    assign w_press = r_db_level & ~r_db_prev;

    // Outputs are decided one cycle ahead so they line up with the state.
    always_comb begin
        w_state_nxt     = r_state;
        w_step_en_nxt   = 1'b0;
        w_done_nxt      = 1'b0;
        w_remaining_nxt = r_remaining;
        w_div_nxt       = r_div;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    case (mode)
                        c_MODE_STEP: begin
                            w_state_nxt   = ST_STEP;
                            w_step_en_nxt = 1'b1;
                        end
                        c_MODE_BURST: begin
                            if (burst_len != '0) begin
                                w_state_nxt     = ST_BURST;
                                w_step_en_nxt   = 1'b1;
                                w_remaining_nxt = burst_len - CNT_W'(1);
                                w_done_nxt      = (burst_len == CNT_W'(1));
                            end
                        end
                        c_MODE_RUN: begin
                            w_state_nxt = ST_RUN;
                            w_div_nxt   = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_BURST: begin
                // r_remaining counts the steps still owed after the current one.
                if ((mode != c_MODE_BURST) || (r_remaining == '0)) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = '0;
                end else begin
                    w_step_en_nxt   = 1'b1;
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                    w_done_nxt      = (r_remaining == CNT_W'(1));
                end
            end
            ST_RUN: begin
                if (w_press || (mode != c_MODE_RUN)) begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                end else if (r_div == run_div) begin
                    w_step_en_nxt = 1'b1;
                    w_div_nxt     = '0;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_BURST) || (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_step_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_remaining  <= '0;
            r_div        <= '0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_step_en    <= w_step_en_nxt;
            r_busy       <= w_busy_nxt;
            r_burst_done <= w_done_nxt;
            r_remaining  <= w_remaining_nxt;
            r_div        <= w_div_nxt;
            if (r_step_en) begin
                r_step_count <= r_step_count + CNT_W'(1);
            end
        end
    end

    assign step_en    = r_step_en;
    assign busy       = r_busy;
    assign burst_done = r_burst_done;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_ctrl
// Purpose  : Self-checking bench for step_ctrl using episode timelines built
//            from button-press timing rules and randomized mode parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_ctrl;

    localparam int D    = 4;
    localparam int CW   = 4;
    localparam int DW   = 4;
    localparam int LAT  = 3 + D;   // button rise -> first STEP/BURST/RUN cycle
    localparam int NMAX = 128;
    localparam int S    = 2;       // button rise cycle inside an episode

    logic          clk = 1'b0;
    logic          reset;
    logic          CLK_BUTT;
    logic [1:0]    mode;
    logic [CW-1:0] burst_len;
    logic [DW-1:0] run_div;
    logic          step_en;
    logic          busy;
    logic          burst_done;
    logic [CW-1:0] step_count;

    always #5 clk = ~clk;

    step_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (CW),
        .DIV_W          (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .CLK_BUTT  (CLK_BUTT),
        .mode      (mode),
        .burst_len (burst_len),
        .run_div   (run_div),
        .step_en   (step_en),
        .busy      (busy),
        .burst_done(burst_done),
        .step_count(step_count)
    );

    int total   = 0;
    int bad     = 0;
    int exp_cnt = 0;
    int n_ep    = 0;
    int plan_len;

    bit            btn_q  [NMAX];
    bit            rst_q  [NMAX];
    bit            e_step [NMAX];
    bit            e_busy [NMAX];
    bit            e_done [NMAX];
    logic [1:0]    mode_q [NMAX];
    logic [CW-1:0] bl_q   [NMAX];
    logic [DW-1:0] rd_cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic new_plan(input logic [1:0] m, input logic [CW-1:0] bl, input logic [DW-1:0] rd);
        for (int i = 0; i < NMAX; i++) begin
            btn_q[i]  = 1'b0;
            rst_q[i]  = 1'b0;
            e_step[i] = 1'b0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            mode_q[i] = m;
            bl_q[i]   = bl;
        end
        rd_cur = rd;
    endtask

    task automatic hold_btn(input int t, input int h);
        for (int i = t; i < t + h; i++) btn_q[i] = 1'b1;
    endtask

    task automatic mode_from(input int t, input logic [1:0] m);
        for (int i = t; i < NMAX; i++) mode_q[i] = m;
    endtask

    task automatic run_plan(input string name);
        n_ep++;
        run_div = rd_cur;
        for (int c = 0; c < plan_len; c++) begin
            @(posedge clk);
            #1;
            if (c > 0 && rst_q[c-1]) exp_cnt = 0;
            reset     = rst_q[c];
            CLK_BUTT  = btn_q[c];
            mode      = mode_q[c];
            burst_len = bl_q[c];
            @(negedge clk);
            check($sformatf("%s#%0d@%0d step_en", name, n_ep, c), step_en, e_step[c]);
            check($sformatf("%s#%0d@%0d busy", name, n_ep, c), busy, e_busy[c]);
            check($sformatf("%s#%0d@%0d burst_done", name, n_ep, c), burst_done, e_done[c]);
            check($sformatf("%s#%0d@%0d step_count", name, n_ep, c), step_count,
                  exp_cnt % (1 << CW));
            if (e_step[c]) exp_cnt++;
        end
    endtask

    // Halt / single-step / glitch: a press exists only if held >= D cycles.
    task automatic ep_step(input logic [1:0] m, input int h);
        new_plan(m, CW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
        hold_btn(S, h);
        if (m == 2'b01 && h >= D) e_step[S+LAT] = 1'b1;
        plan_len = S + h + D + 8;
        run_plan("step");
    endtask

    task automatic ep_burst(input int len, input int h, input int abort_at, input bit chg_bl);
        int p;
        int last;
        p = S + LAT;
        new_plan(2'b10, CW'(len), DW'($urandom_range(0, 15)));
        hold_btn(S, h);
        if (chg_bl) for (int i = p + 1; i < NMAX; i++) bl_q[i] = CW'($urandom_range(0, 15));
        last = p + len - 1;
        if (abort_at >= 0) begin
            mode_from(p + abort_at, 2'b00);
            if (p + abort_at < last) last = p + abort_at;
        end
        for (int c = p; c <= last; c++) begin
            e_step[c] = 1'b1;
            e_busy[c] = 1'b1;
        end
        if (len != 0 && last == p + len - 1) e_done[last] = 1'b1;
        plan_len = ((p + len > S + h + D) ? p + len : S + h + D) + 6;
        run_plan("burst");
    endtask

    // Free run: stopped either by a second press (how=0) or by leaving mode 11.
    task automatic ep_run(input int r, input int h, input int how, input int gap);
        int p;
        int q;
        int s2;
        int rel;
        p = S + LAT;
        new_plan(2'b11, CW'($urandom_range(0, 15)), DW'(r));
        hold_btn(S, h);
        if (how == 0) begin
            s2 = S + h + D + 2 + gap;
            hold_btn(s2, D + 1);
            q   = s2 + LAT;
            rel = s2 + D + 1;
        end else begin
            mode_from(p + gap, 2'b00);
            q   = p + gap + 1;
            rel = S + h;
        end
        for (int c = p; c < q; c++) begin
            e_busy[c] = 1'b1;
            if (c > p && ((c - p) % (r + 1)) == 0) e_step[c] = 1'b1;
        end
        plan_len = ((q > rel + D) ? q : rel + D) + 6;
        run_plan("run");
    endtask

    task automatic ep_reset_run();
        int p;
        int x;
        p = S + LAT;
        x = p + 5;
        new_plan(2'b11, 4'd3, 4'd0);
        hold_btn(S, D + 1);
        rst_q[x]   = 1'b1;
        rst_q[x+1] = 1'b1;
        for (int c = p; c <= x; c++) begin
            e_busy[c] = 1'b1;
            if (c > p) e_step[c] = 1'b1;
        end
        plan_len = x + 8;
        run_plan("rst_run");
    endtask

    // Button already high while reset is held; counts from reset release.
    task automatic ep_held_reset();
        int x;
        x = 5;
        new_plan(2'b01, 4'd0, 4'd0);
        for (int i = 0; i < x; i++) rst_q[i] = 1'b1;
        hold_btn(0, x + D + 2);
        e_step[x+LAT] = 1'b1;
        plan_len = x + D + 2 + D + 8;
        run_plan("rst_hold");
    endtask

    initial begin
        reset     = 1'b1;
        CLK_BUTT  = 1'b0;
        mode      = 2'b00;
        burst_len = '0;
        run_div   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset step_en", step_en, 0);
        check("reset busy", busy, 0);
        check("reset burst_done", burst_done, 0);
        check("reset step_count", step_count, 0);

        ep_step(2'b01, 20);
        ep_step(2'b01, 3);
        ep_burst(5, D + 1, -1, 1'b1);
        ep_run(3, D + 1, 0, 16);
        ep_burst(8, D + 1, 3, 1'b0);
        for (int k = 0; k < 17; k++) ep_step(2'b01, D + 1);
        ep_step(2'b00, D + 2);
        ep_burst(0, D + 1, -1, 1'b0);
        ep_burst(1, D, -1, 1'b0);
        ep_run(0, D + 1, 1, 6);

        for (int k = 0; k < 40; k++) begin
            int kind;
            int h;
            int len;
            kind = $urandom_range(0, 6);
            h    = $urandom_range(D, D + 6);
            case (kind)
                0: ep_step(2'b00, h);
                1: ep_step(2'b01, h);
                2: ep_step(2'($urandom_range(0, 3)), $urandom_range(1, D - 1));
                3: ep_burst($urandom_range(0, 15), h, -1, 1'($urandom_range(0, 1)));
                4: begin
                    len = $urandom_range(2, 15);
                    ep_burst(len, h, $urandom_range(0, len - 2), 1'b0);
                end
                5: ep_run($urandom_range(0, 7), h, 0, $urandom_range(0, 20));
                default: ep_run($urandom_range(0, 7), h, 1, $urandom_range(0, 15));
            endcase
        end

        ep_reset_run();
        ep_held_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
